// File: rtl/max_result_serializer_if.sv
// Output beat stream of the result serializer: valid/ready handshake with end-of-result marker.
interface max_result_serializer_if #(
    parameter int unsigned OUT_WIDTH = 8
) ();
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (output out_data, output out_valid, output out_last, input  out_ready);
    modport slave  (input  out_data, input  out_valid, input  out_last, output out_ready);
endinterface

// File: rtl/max_result_serializer.sv
// Snapshots the final best-cell result on done and drains it LSB-first as OUT_WIDTH beats,
// so the max registers can be cleared for the next alignment while the old result streams out.
module max_result_serializer #(
    parameter int unsigned SCORE_WIDTH    = 16,
    parameter int unsigned ROW_BITS_WIDTH = 8,
    parameter int unsigned COL_BITS_WIDTH = 8,
    parameter int unsigned OUT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      done,
    input  logic [SCORE_WIDTH-1:0]    max_score,
    input  logic [ROW_BITS_WIDTH-1:0] max_row,
    input  logic [COL_BITS_WIDTH-1:0] max_col,
    max_result_serializer_if.master   bus,
    output logic                      busy,
    output logic                      result_sent,
    output logic                      overrun
);

    localparam int unsigned TOTAL_W   = SCORE_WIDTH + ROW_BITS_WIDTH + COL_BITS_WIDTH;
    localparam int unsigned NUM_BEATS = (TOTAL_W + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int unsigned SNAP_W    = NUM_BEATS * OUT_WIDTH;
    localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state, state_d;
    logic [SNAP_W-1:0]    snapshot, snapshot_d;
    logic [CNT_W-1:0]     beat_cnt, beat_cnt_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 sent_q, sent_d;
    logic                 overrun_q, overrun_d;
    logic                 handshake_c;
    logic                 last_hs_c;

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign busy          = valid_q;
    assign result_sent   = sent_q;
    assign overrun       = overrun_q;

    assign handshake_c = valid_q && bus.out_ready;
    assign last_hs_c   = handshake_c && (beat_cnt == LAST_BEAT);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            snapshot  <= '0;
            beat_cnt  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            sent_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_d;
            snapshot  <= snapshot_d;
            beat_cnt  <= beat_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            sent_q    <= sent_d;
            overrun_q <= overrun_d;
        end
    end

    // Next state; outputs are precomputed from the next snapshot/count so they register cleanly
    always_comb begin
        state_d    = state;
        snapshot_d = snapshot;
        beat_cnt_d = beat_cnt;
        sent_d     = 1'b0;
        overrun_d  = overrun_q;
        data_d     = '0;
        valid_d    = 1'b0;
        last_d     = 1'b0;

        if (start) begin
            overrun_d = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (done) begin
                    snapshot_d = SNAP_W'({max_score, max_row, max_col});
                    beat_cnt_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (last_hs_c) begin
                    sent_d     = 1'b1;
                    beat_cnt_d = '0;
                    if (done) begin
                        snapshot_d = SNAP_W'({max_score, max_row, max_col});
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (handshake_c) begin
                        beat_cnt_d = beat_cnt + CNT_W'(1);
                    end
                    // A result still in flight wins; the new one is dropped and flagged
                    if (done) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == SEND) begin
            valid_d = 1'b1;
            data_d  = OUT_WIDTH'(snapshot_d >> (32'(beat_cnt_d) * OUT_WIDTH));
            last_d  = (beat_cnt_d == LAST_BEAT);
        end
    end

endmodule
